// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU op codes, sequencer state encodings and the ALU request bundle
// used by the multiply sequencer and its magnitude helper.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [1:0] MSEQ_IDLE = 2'd0;
  localparam logic [1:0] MSEQ_STEP = 2'd1;
  localparam logic [1:0] MSEQ_NEG  = 2'd2;
  localparam logic [1:0] MSEQ_DONE = 2'd3;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] src0;
    logic [15:0] src1;
    logic [3:0]  sh_amt;
  } alu_req_t;

endpackage

// File: rtl/alu_mul_sequencer_mag16.sv
// Combinational two's-complement magnitude; 16'h8000 maps to 16'h8000,
// which reads correctly as 32768 when treated as unsigned.
module alu_mul_sequencer_mag16 (
  input  logic [15:0] val_i,
  output logic [15:0] mag_o
);

  assign mag_o = val_i[15] ? (~val_i + 16'd1) : val_i;

endmodule

// File: rtl/alu_mul_sequencer.sv
// Signed 16x16->16 saturating shift-add multiplier that borrows the shared ALU
// for its add/negate steps; MUL_EARLY_TERM_EN stops once the multiplier runs out.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_req,
  input  logic [3:0]  pipe_aluOp,
  input  logic [15:0] pipe_src0,
  input  logic [15:0] pipe_src1,
  input  logic [3:0]  pipe_shAmt,
  input  logic        mul_start,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  input  logic [15:0] alu_dst,
  input  logic        alu_V,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_src0,
  output logic [15:0] alu_src1,
  output logic [3:0]  alu_shAmt,
  output logic        pipe_stall,
  output logic        mul_busy,
  output logic        mul_done,
  output logic [15:0] mul_result,
  output logic        mul_V
);

  localparam logic [3:0] STARVE_CNT = STARVE_LIMIT[3:0];

  logic [1:0]  state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] res_q, res_d;
  logic        v_q, v_d;

  logic [15:0] a_mag, b_mag;
  logic        need, grant, last;
  logic        ovf_nxt;
  logic [15:0] acc_nxt;
  logic [15:0] sat_val;
  alu_req_t    seq_bus, pipe_bus;

  alu_mul_sequencer_mag16 u_mag_a (.val_i(mul_a), .mag_o(a_mag));
  alu_mul_sequencer_mag16 u_mag_b (.val_i(mul_b), .mag_o(b_mag));

  // An add whose multiplicand already reached bit 15 is an overflow, not an ALU request.
  assign need  = ((state_q == MSEQ_STEP) & mplier_q[0] & ~mcand_q[15]) | (state_q == MSEQ_NEG);
  assign grant = need & (~pipe_req | (wait_q == STARVE_CNT));

  always_comb begin
    seq_bus.op     = (state_q == MSEQ_NEG) ? ALU_SUB : ALU_ADD;
    seq_bus.src0   = (state_q == MSEQ_NEG) ? 16'h0000 : acc_q;
    seq_bus.src1   = (state_q == MSEQ_NEG) ? acc_q : mcand_q;
    seq_bus.sh_amt = 4'd0;
  end

  assign pipe_bus = '{op: pipe_aluOp, src0: pipe_src0, src1: pipe_src1, sh_amt: pipe_shAmt};
  assign {alu_op, alu_src0, alu_src1, alu_shAmt} = grant ? seq_bus : pipe_bus;
  assign pipe_stall = grant & pipe_req;

  assign sat_val    = neg_q ? 16'h8000 : 16'h7FFF;
  assign mul_busy   = (state_q != MSEQ_IDLE);
  assign mul_done   = (state_q == MSEQ_DONE);
  assign mul_result = mul_done ? (ovf_q ? sat_val : acc_q) : res_q;
  assign mul_V      = mul_done ? ovf_q : v_q;

  always_comb begin
    acc_nxt = need ? alu_dst : acc_q;
    ovf_nxt = (need & alu_V) | (mcand_q[15] & (mplier_q[15:1] != 15'd0));
`ifdef MUL_EARLY_TERM_EN
    last    = (cnt_q == 4'd15) | (mplier_q[15:1] == 15'd0);
`else
    last    = (cnt_q == 4'd15);
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    v_d      = v_q;

    if ((state_q == MSEQ_IDLE) || grant) begin
      wait_d = 4'd0;
    end else if (need & pipe_req) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    case (state_q)
      MSEQ_IDLE: begin
        if (mul_start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = 16'h0000;
          neg_d    = mul_a[15] ^ mul_b[15];
          cnt_d    = 4'd0;
          ovf_d    = 1'b0;
          state_d  = MSEQ_STEP;
        end
      end
      MSEQ_STEP: begin
        if (mplier_q[0] & mcand_q[15]) begin
          ovf_d   = 1'b1;
          state_d = MSEQ_DONE;
        end else if (~need | grant) begin
          acc_d    = acc_nxt;
          mcand_d  = {mcand_q[14:0], 1'b0};
          mplier_d = {1'b0, mplier_q[15:1]};
          cnt_d    = cnt_q + 4'd1;
          if (ovf_nxt) begin
            ovf_d   = 1'b1;
            state_d = MSEQ_DONE;
          end else if (last) begin
            state_d = (neg_q && (acc_nxt != 16'h0000)) ? MSEQ_NEG : MSEQ_DONE;
          end
        end
      end
      MSEQ_NEG: begin
        if (grant) begin
          acc_d   = alu_dst;
          state_d = MSEQ_DONE;
        end
      end
      default: begin
        // Latch the presented result so it survives the return to IDLE.
        res_d   = ovf_q ? sat_val : acc_q;
        v_d     = ovf_q;
        state_d = MSEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MSEQ_IDLE;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      acc_q    <= 16'h0000;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 4'd0;
      wait_q   <= 4'd0;
      res_q    <= 16'h0000;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      res_q    <= res_d;
      v_q      <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboarded bench: an arithmetic model predicts each product and ALU-steal counts;
// a negedge monitor compares on mul_done and checks stall/passthrough every cycle.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        v;
    int          adds;
    int          subs;
    bit          chk_steal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_req;
  logic [3:0]  pipe_aluOp;
  logic [15:0] pipe_src0, pipe_src1;
  logic [3:0]  pipe_shAmt;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic [15:0] alu_dst;
  logic        alu_V;
  logic [3:0]  alu_op;
  logic [15:0] alu_src0, alu_src1;
  logic [3:0]  alu_shAmt;
  logic        pipe_stall, mul_busy, mul_done, mul_V;
  logic [15:0] mul_result;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   req_mode = 0;
  int   adds_seen = 0, subs_seen = 0, others_seen = 0;
  exp_t sb[$];
  int   stall_log[$];

  alu_mul_sequencer #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(pipe_req), .pipe_aluOp(pipe_aluOp), .pipe_src0(pipe_src0),
    .pipe_src1(pipe_src1), .pipe_shAmt(pipe_shAmt),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .alu_dst(alu_dst), .alu_V(alu_V),
    .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_shAmt(alu_shAmt),
    .pipe_stall(pipe_stall), .mul_busy(mul_busy), .mul_done(mul_done),
    .mul_result(mul_result), .mul_V(mul_V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU
  always_comb begin
    logic [15:0] r;
    r = alu_src0 ^ alu_src1;
    alu_V = 1'b0;
    if (alu_op == ALU_ADD) begin
      r = alu_src0 + alu_src1;
      alu_V = (alu_src0[15] == alu_src1[15]) && (r[15] != alu_src0[15]);
    end else if (alu_op == ALU_SUB) begin
      r = alu_src0 - alu_src1;
      alu_V = (alu_src0[15] != alu_src1[15]) && (r[15] != alu_src0[15]);
    end
    alu_dst = r;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ma, mb, m;
    logic neg;
    logic [15:0] mbv;
    ma  = a[15] ? 65536 - int'(a) : int'(a);
    mb  = b[15] ? 65536 - int'(b) : int'(b);
    m   = ma * mb;
    neg = a[15] ^ b[15];
    mbv = mb[15:0];
    e.adds = $countones(mbv);
    e.subs = (neg && m != 0) ? 1 : 0;
    if (m >= 32768) begin
      e.res = neg ? 16'h8000 : 16'h7FFF;
      e.v = 1'b1;
      e.chk_steal = 1'b0;
    end else begin
      e.res = neg ? 16'(-m) : 16'(m);
      e.v = 1'b0;
      e.chk_steal = 1'b1;
    end
    return e;
  endfunction

  // Pipeline traffic; shift amount never 0 so a stolen cycle always differs from passthrough.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pipe_req   = (req_mode == 0) ? 1'b0 : (req_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      pipe_aluOp = 4'($urandom);
      pipe_src0  = 16'($urandom);
      pipe_src1  = 16'($urandom);
      pipe_shAmt = 4'($urandom_range(1, 15));
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        adds_seen = 0; subs_seen = 0; others_seen = 0;
      end else begin
        logic steal;
        steal = {alu_op, alu_src0, alu_src1, alu_shAmt} !=
                {pipe_aluOp, pipe_src0, pipe_src1, pipe_shAmt};
        if (steal) begin
          if (alu_op == ALU_ADD) adds_seen++;
          else if (alu_op == ALU_SUB) begin
            subs_seen++;
            chk("neg_src0", alu_src0, 32'h0);
          end else others_seen++;
        end
        if (pipe_req) chk("stall_vs_steal", pipe_stall, steal);
        else chk("stall_without_req", pipe_stall, 1'b0);
        if (pipe_stall) stall_log.push_back(cyc);
        if (mul_done) begin
          chk("done_expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("mul_result", mul_result, e.res);
            chk("mul_V", mul_V, e.v);
            chk("steal_other_op", others_seen, 0);
            if (e.chk_steal) begin
              chk("add_steals", adds_seen, e.adds);
              chk("neg_steals", subs_seen, e.subs);
            end
          end
          adds_seen = 0; subs_seen = 0; others_seen = 0;
        end
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int poke,
                        output int t0, output int lat);
    sb.push_back(model(a, b));
    stall_log.delete();
    @(posedge clk);
    #1;
    mul_start = 1'b1; mul_a = a; mul_b = b; t0 = cyc;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (mul_done) begin
          lat = cyc - t0;
          break;
        end
        mul_start = (k == poke);
        if (k == poke) begin
          chk("busy_at_poke", mul_busy, 1'b1);
          mul_a = 16'($urandom); mul_b = 16'($urandom);
        end
      end
    end
    mul_start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int t0, lat;
    logic [15:0] ra, rb;
    rst_n = 1'b0; mul_start = 1'b0; mul_a = '0; mul_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", mul_busy, 1'b0);
    chk("rst_done", mul_done, 1'b0);
    chk("rst_result", mul_result, 32'h0);
    chk("rst_V", mul_V, 1'b0);
    chk("rst_stall", pipe_stall, 1'b0);
    rst_n = 1'b1;

    req_mode = 0;
    run_op(16'd3, 16'd5, 1000, t0, lat);
`ifdef MUL_EARLY_TERM_EN
    chk("lat_3x5", lat, 4);
`else
    chk("lat_3x5", lat, 17);
`endif
    chk("result_hold", mul_result, 32'h000F);

    run_op(16'hFFF9, 16'd6, 1000, t0, lat);
    run_op(16'd300, 16'd200, 1000, t0, lat);
    chk("sat_pos_early", lat < 17, 1'b1);
    run_op(16'hFED4, 16'd200, 1000, t0, lat);
    chk("sat_neg_early", lat < 17, 1'b1);
    run_op(16'h8000, 16'd1, 1000, t0, lat);

    req_mode = 1;
    run_op(16'd3, 16'd5, 1000, t0, lat);
    chk("starve_stalls", stall_log.size(), 2);
    if (stall_log.size() == 2) begin
      chk("starve_stall0", stall_log[0] - t0, 5);
      chk("starve_stall1", stall_log[1] - t0, 11);
    end
    req_mode = 0;

    // Asynchronous reset part-way through a multiply
    sb.push_back(model(16'd3, 16'd5));
    @(posedge clk);
    #1;
    mul_start = 1'b1; mul_a = 16'd3; mul_b = 16'd5;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", mul_busy, 1'b0);
    chk("arst_done", mul_done, 1'b0);
    chk("arst_result", mul_result, 32'h0);
    chk("arst_V", mul_V, 1'b0);
    chk("arst_stall", pipe_stall, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd2, 16'd2, 1000, t0, lat);

    run_op(16'd0, 16'hFFF7, 2, t0, lat);
    chk("ignored_start_result", mul_result, 32'h0);

    req_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 16'($urandom); rb = 16'($urandom);
      end else begin
        ra = 16'($urandom_range(0, 362)) - 16'd181;
        rb = 16'($urandom_range(0, 362)) - 16'd181;
      end
      run_op(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 1000, t0, lat);
    end
    req_mode = 0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
